barrel_sched: RTL
=================

BARREL_SCHED -- requirements
Module: barrel_sched

Interface
REQ-001 SHALL have parameter BITS_THREADS, default 3, meaning the width of a thread ID.
REQ-002 SHALL have parameter NUM_THREADS, default 2**BITS_THREADS, meaning the number of hardware threads scheduled.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall_i  in  1  pipeline stall; when high, no issue occurs and the round-robin pointer holds.
REQ-006 start_i, start_tid_i  in  1, BITS_THREADS  request to move the named thread from IDLE to READY.
REQ-007 halt_i, halt_tid_i  in  1, BITS_THREADS  request to move the named thread to IDLE.
REQ-008 block_i, block_tid_i  in  1, BITS_THREADS  the named thread blocks (load, branch) and enters WAIT.
REQ-009 wake_i, wake_tid_i  in  1, BITS_THREADS  the named WAIT thread returns to READY.
REQ-010 issue_valid_o  out  1  registered; high when tid_f_o names a thread issuing to fetch this cycle.
REQ-011 tid_f_o  out  BITS_THREADS  registered thread ID of the issuing thread.
REQ-012 ready_mask_o  out  NUM_THREADS  registered; bit t is high when thread t is READY.
REQ-013 all_idle_o  out  1  high when every thread is IDLE.

Function
REQ-014 Each thread SHALL hold a 2-bit state: IDLE=0, READY=1, WAIT=2.
REQ-015 Per-thread transitions SHALL apply in this priority order: halt (any state to IDLE); block (READY to WAIT); wake (WAIT to READY); start (IDLE to READY); otherwise hold.
REQ-016 A start on a non-IDLE thread, a wake on a non-WAIT thread and a block on a non-READY thread SHALL be ignored.
REQ-017 Block and wake on the same tid in the same cycle: a READY thread SHALL end in WAIT; a WAIT thread SHALL end in READY.
REQ-018 Eligibility SHALL equal state==READY, excluding any tid named by a halt or block arriving in that cycle.
REQ-019 Selection SHALL be round-robin: search from (last_tid+1) mod NUM_THREADS upward with wrap-around; the first eligible tid wins.
REQ-020 When stall_i is low and at least one thread is eligible, the next cycle SHALL have issue_valid_o=1 and tid_f_o=winner, and last_tid SHALL become the winner.
REQ-021 When stall_i is high or no thread is eligible, the next cycle SHALL have issue_valid_o=0; tid_f_o and last_tid SHALL hold.
REQ-022 Issue latency SHALL be exactly 1 cycle from the eligible state to the registered output.
REQ-023 A single READY thread SHALL issue on every unstalled cycle.
REQ-024 With N READY threads, each SHALL issue exactly once in any N consecutive unstalled issue cycles.
REQ-025 ready_mask_o SHALL reflect the registered thread states; all_idle_o SHALL be derived combinationally from the registered states.

Reset
REQ-026 While rst is high, every thread SHALL be IDLE, and issue_valid_o=0, tid_f_o=0, ready_mask_o=0.
REQ-027 While rst is high, last_tid SHALL be NUM_THREADS-1, so the first issue after reset searches from thread 0.
REQ-028 rst SHALL override all requests in the same cycle; an issue in flight SHALL be dropped.

Structure
REQ-029 The thread-state encodings (IDLE, READY, WAIT) SHALL be defined in a shared package, barrel_pkg, together with BITS_THREADS.
REQ-030 The round-robin search SHALL be a sub-module rr_pick, inputs eligible mask and last_tid, outputs winner and found.
REQ-031 The block SHALL contain no memory other than the per-thread state registers, last_tid and the output registers.

Verification
REQ-032 Reset, then start tid 0, 3 and 5 in one cycle each, stall_i=0: tid_f_o SHALL issue the sequence 0,3,5,0,3,5 with issue_valid_o=1.
REQ-033 Threads 2 and 6 READY, block tid 2: the next issues SHALL be 6,6,6; after wake tid 2, the sequence SHALL return to 2,6 alternating.
REQ-034 All 8 threads READY, stall_i=1 for 3 cycles after tid 4 issues: issue_valid_o=0 for 3 cycles, then the next issue SHALL be tid 5.
REQ-035 Thread 7 READY, block and wake tid 7 in the same cycle: the thread SHALL end in WAIT with no issue; a later wake tid 7 SHALL restore issue.
REQ-036 Thread 1 WAIT, halt tid 1 and wake tid 1 in the same cycle: the thread SHALL end IDLE, and all_idle_o=1 if it was the only thread.
REQ-037 Assert rst mid-stream with 4 threads READY: the next cycle SHALL show issue_valid_o=0 and ready_mask_o=0; start tid 3 SHALL then issue tid 3.

Source files
------------

// File: rtl/barrel_pkg.sv
// barrel_pkg -- shared definitions for the barrel thread scheduler.
//   BITS_THREADS   : default width of a thread ID
//   thread_state_t : per-thread scheduling state (IDLE / READY / WAIT)
package barrel_pkg;

  localparam int BITS_THREADS = 3;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_READY = 2'd1,
    TS_WAIT  = 2'd2
  } thread_state_t;

endpackage

// File: rtl/barrel_sched_if.sv
// barrel_sched_if -- request and issue signals of the barrel scheduler.
//   Requests (master drives): stall_i, start_*, halt_*, block_*, wake_*
//   Results  (slave drives) : issue_valid_o, tid_f_o, ready_mask_o,
//                             all_idle_o, state_dbg_o (2 bits per thread)
//
// Handshake: issue_valid_o qualifies tid_f_o for exactly one cycle; there is
// no ready/acknowledge path. The consumer applies backpressure only through
// stall_i, which suppresses the issue computed in that cycle. Each request
// strobe (start/halt/block/wake) is a single-cycle command naming one tid.
interface barrel_sched_if #(
  parameter int BITS_THREADS = barrel_pkg::BITS_THREADS,
  parameter int NUM_THREADS  = 2 ** BITS_THREADS
);

  logic                      stall_i;
  logic                      start_i;
  logic [BITS_THREADS-1:0]   start_tid_i;
  logic                      halt_i;
  logic [BITS_THREADS-1:0]   halt_tid_i;
  logic                      block_i;
  logic [BITS_THREADS-1:0]   block_tid_i;
  logic                      wake_i;
  logic [BITS_THREADS-1:0]   wake_tid_i;

  logic                      issue_valid_o;
  logic [BITS_THREADS-1:0]   tid_f_o;
  logic [NUM_THREADS-1:0]    ready_mask_o;
  logic                      all_idle_o;
  logic [2*NUM_THREADS-1:0]  state_dbg_o;

  modport master (
    output stall_i, start_i, start_tid_i, halt_i, halt_tid_i,
           block_i, block_tid_i, wake_i, wake_tid_i,
    input  issue_valid_o, tid_f_o, ready_mask_o, all_idle_o, state_dbg_o
  );

  modport slave (
    input  stall_i, start_i, start_tid_i, halt_i, halt_tid_i,
           block_i, block_tid_i, wake_i, wake_tid_i,
    output issue_valid_o, tid_f_o, ready_mask_o, all_idle_o, state_dbg_o
  );

endinterface

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin picker.
//   eligible : one bit per thread, high when the thread may issue
//   last_tid : most recently issued thread
//   winner   : first eligible tid searching upward from last_tid+1 (wrapping)
//   found    : high when any thread is eligible
module rr_pick #(
  parameter int BITS_THREADS = 3,
  parameter int NUM_THREADS  = 2 ** BITS_THREADS
) (
  input  logic [NUM_THREADS-1:0]  eligible,
  input  logic [BITS_THREADS-1:0] last_tid,
  output logic [BITS_THREADS-1:0] winner,
  output logic                    found
);

  always_comb begin : pick
    logic [BITS_THREADS:0]   sum;
    logic [BITS_THREADS-1:0] idx;
    winner = last_tid;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    // Offset k=NUM_THREADS comes back to last_tid itself, so a lone eligible
    // thread that just issued is picked again.
    for (int k = 1; k <= NUM_THREADS; k++) begin
      sum = {1'b0, last_tid} + (BITS_THREADS+1)'(k);
      if (sum >= (BITS_THREADS+1)'(NUM_THREADS))
        sum = sum - (BITS_THREADS+1)'(NUM_THREADS);
      idx = sum[BITS_THREADS-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/barrel_sched.sv
// barrel_sched -- barrel (fine-grained multithreading) issue scheduler.
//   clk, rst : clock and synchronous active-high reset
//   bus      : barrel_sched_if slave port (requests in, issue/status out)
// Each thread carries an IDLE/READY/WAIT state. Every unstalled cycle one
// READY thread is chosen round-robin and presented, registered, on tid_f_o
// the following cycle.
module barrel_sched #(
  parameter int BITS_THREADS = barrel_pkg::BITS_THREADS,
  parameter int NUM_THREADS  = 2 ** BITS_THREADS
) (
  input  logic          clk,
  input  logic          rst,
  barrel_sched_if.slave bus
);

  import barrel_pkg::*;

  thread_state_t           state_q [NUM_THREADS];
  thread_state_t           state_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]  halt_hit, block_hit, wake_hit, start_hit;
  logic [NUM_THREADS-1:0]  eligible, ready_d, ready_mask_q;
  logic [BITS_THREADS-1:0] last_tid_q, tid_q, winner;
  logic                    found, issue_valid_q, all_idle;

  always_comb begin
    halt_hit  = '0;
    block_hit = '0;
    wake_hit  = '0;
    start_hit = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      halt_hit[t]  = bus.halt_i  && (bus.halt_tid_i  == BITS_THREADS'(t));
      block_hit[t] = bus.block_i && (bus.block_tid_i == BITS_THREADS'(t));
      wake_hit[t]  = bus.wake_i  && (bus.wake_tid_i  == BITS_THREADS'(t));
      start_hit[t] = bus.start_i && (bus.start_tid_i == BITS_THREADS'(t));
    end
  end

  // Per-thread next state. Each branch is guarded by the current state, so a
  // request that does not fit the thread's state falls through and is
  // ignored; block+wake on one tid therefore resolves by the current state.
  always_comb begin
    eligible = '0;
    ready_d  = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      state_d[t] = state_q[t];
      if (halt_hit[t])
        state_d[t] = TS_IDLE;
      else if (block_hit[t] && state_q[t] == TS_READY)
        state_d[t] = TS_WAIT;
      else if (wake_hit[t] && state_q[t] == TS_WAIT)
        state_d[t] = TS_READY;
      else if (start_hit[t] && state_q[t] == TS_IDLE)
        state_d[t] = TS_READY;

      // A thread being halted or blocked this cycle must not issue now.
      eligible[t] = (state_q[t] == TS_READY) && !halt_hit[t] && !block_hit[t];
      ready_d[t]  = (state_d[t] == TS_READY);
    end
  end

  rr_pick #(
    .BITS_THREADS (BITS_THREADS),
    .NUM_THREADS  (NUM_THREADS)
  ) u_rr_pick (
    .eligible (eligible),
    .last_tid (last_tid_q),
    .winner   (winner),
    .found    (found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= TS_IDLE;
      ready_mask_q  <= '0;
      issue_valid_q <= 1'b0;
      tid_q         <= '0;
      // Start the search at thread 0 after reset.
      last_tid_q    <= BITS_THREADS'(NUM_THREADS - 1);
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) state_q[t] <= state_d[t];
      ready_mask_q <= ready_d;
      if (!bus.stall_i && found) begin
        issue_valid_q <= 1'b1;
        tid_q         <= winner;
        last_tid_q    <= winner;
      end else begin
        issue_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    all_idle = 1'b1;
    for (int t = 0; t < NUM_THREADS; t++)
      if (state_q[t] != TS_IDLE) all_idle = 1'b0;
  end

  always_comb begin
    bus.state_dbg_o = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      bus.state_dbg_o[2*t +: 2] = state_q[t];
  end

  assign bus.issue_valid_o = issue_valid_q;
  assign bus.tid_f_o       = tid_q;
  assign bus.ready_mask_o  = ready_mask_q;
  assign bus.all_idle_o    = all_idle;

endmodule
